// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA mode scheduler.
// Holds the scheduler state encoding, field widths, osel codes and the AUTO next-mode search.
package vga_sched_pkg;

   localparam int MODE_W = 3;
   localparam int OSEL_W = 2;

   localparam logic [OSEL_W-1:0] OSEL_R   = 2'd0;
   localparam logic [OSEL_W-1:0] OSEL_G   = 2'd1;
   localparam logic [OSEL_W-1:0] OSEL_B   = 2'd2;
   localparam logic [OSEL_W-1:0] OSEL_OFF = 2'd3;

   typedef enum logic [0:0] {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } sched_state_t;

   // Lowest enabled mode strictly after cur, wrapping; an empty mask leaves cur unchanged.
   function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                   input logic [7:0]        mask);
      logic [MODE_W-1:0] res;
      logic [MODE_W-1:0] cand;
      logic              found;
      res   = cur;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cand = cur + MODE_W'(i);
         if (!found && mask[cand]) begin
            res   = cand;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_sched_sync.sv
// W-bit two-flop synchroniser for asynchronous pins, asynchronous active-high reset to 0.
module vga_sched_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/vga_mode_scheduler.sv
// Frame-synchronous configuration controller: reloads core mode/options only at vsync active edges.
// Define MODESCHED_AUTO_EN to build the AUTO mode stepper (dwell counter, step button, MODE_MASK).
module vga_mode_scheduler
   import vga_sched_pkg::*;
#(
   parameter int         DWELL_FRAMES  = 60,
   parameter logic [7:0] MODE_MASK     = 8'hFF,
   parameter int         VSYNC_ACT_LOW = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic [MODE_W-1:0] ui_mode,
   input  logic              ui_mixnoise,
   input  logic              ui_usewobble,
   input  logic [OSEL_W-1:0] ui_osel,
   input  logic              ui_auto,
   input  logic              ui_step,
   output logic [MODE_W-1:0] inymode,
   output logic              mixnoise,
   output logic              usewobble,
   output logic [OSEL_W-1:0] osel,
   output logic              cfg_update,
   output logic [7:0]        frame_count
);

   localparam int   SYNC_W     = MODE_W + OSEL_W + 4;
   localparam logic VS_ACT_LVL = (VSYNC_ACT_LOW != 0) ? 1'b0 : 1'b1;

   logic [SYNC_W-1:0] pins_raw;
   logic [SYNC_W-1:0] pins_s;
   logic [MODE_W-1:0] mode_s;
   logic              mix_s;
   logic              wob_s;
   logic [OSEL_W-1:0] osel_s;
   logic              auto_s;
   logic              step_s;

   assign pins_raw = {ui_step, ui_auto, ui_osel, ui_usewobble, ui_mixnoise, ui_mode};

   vga_sched_sync #(
      .W (SYNC_W)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pins_raw),
      .q   (pins_s)
   );

   assign mode_s = pins_s[MODE_W-1:0];
   assign mix_s  = pins_s[MODE_W];
   assign wob_s  = pins_s[MODE_W+1];
   assign osel_s = pins_s[MODE_W+2 +: OSEL_W];
   assign auto_s = pins_s[MODE_W+OSEL_W+2];
   assign step_s = pins_s[MODE_W+OSEL_W+3];

   // Frame boundary detect; hist_valid_reg keeps the first post-reset sample from firing fb.
   logic       vs_reg;
   logic       vs_prev_reg;
   logic [1:0] hist_valid_reg;
   logic       vs_act;
   logic       vs_prev_act;
   logic       fb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_reg         <= 1'b0;
         vs_prev_reg    <= 1'b0;
         hist_valid_reg <= 2'b00;
      end else begin
         vs_reg         <= vsync;
         vs_prev_reg    <= vs_reg;
         hist_valid_reg <= {hist_valid_reg[0], 1'b1};
      end
   end

   assign vs_act      = (vs_reg == VS_ACT_LVL);
   assign vs_prev_act = (vs_prev_reg == VS_ACT_LVL);
   assign fb          = hist_valid_reg[1] & vs_act & ~vs_prev_act;

   logic [MODE_W-1:0] inymode_reg;
   logic [MODE_W-1:0] inymode_next;
   logic              mixnoise_reg;
   logic              usewobble_reg;
   logic [OSEL_W-1:0] osel_reg;
   logic              cfg_update_reg;
   logic [7:0]        frame_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inymode_reg     <= '0;
         mixnoise_reg    <= 1'b0;
         usewobble_reg   <= 1'b0;
         osel_reg        <= OSEL_R;
         cfg_update_reg  <= 1'b0;
         frame_count_reg <= 8'd0;
      end else begin
         cfg_update_reg <= fb;
         inymode_reg    <= inymode_next;
         if (fb) begin
            mixnoise_reg    <= mix_s;
            usewobble_reg   <= wob_s;
            osel_reg        <= osel_s;
            frame_count_reg <= frame_count_reg + 8'd1;
         end
      end
   end

`ifdef MODESCHED_AUTO_EN
   localparam int                 DWELL_W    = $clog2(DWELL_FRAMES + 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

   sched_state_t       state_reg;
   sched_state_t       state_next;
   logic [DWELL_W-1:0] dwell_reg;
   logic [DWELL_W-1:0] dwell_next;
   logic               step_prev_reg;
   logic               step_evt;

   // ui_step is only looked at on frame boundaries, which debounces the button.
   assign step_evt = step_s & ~step_prev_reg;

   always_comb begin
      state_next   = state_reg;
      dwell_next   = dwell_reg;
      inymode_next = inymode_reg;
      if (fb) begin
         case (state_reg)
            ST_MANUAL: begin
               if (auto_s) begin
                  state_next = ST_AUTO;
                  dwell_next = '0;
               end else begin
                  inymode_next = mode_s;
               end
            end
            ST_AUTO: begin
               if (!auto_s) begin
                  state_next   = ST_MANUAL;
                  inymode_next = mode_s;
               end else if (step_evt || (dwell_reg == DWELL_LAST)) begin
                  inymode_next = next_mode(inymode_reg, MODE_MASK);
                  dwell_next   = '0;
               end else begin
                  dwell_next = dwell_reg + DWELL_W'(1);
               end
            end
            default: state_next = ST_MANUAL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_MANUAL;
         dwell_reg     <= '0;
         step_prev_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         dwell_reg <= dwell_next;
         if (fb) begin
            step_prev_reg <= step_s;
         end
      end
   end
`else
   // Manual-only build: inymode follows the pins at every frame boundary.
   assign inymode_next = fb ? mode_s : inymode_reg;

   logic _unused;
   assign _unused = &{1'b0, auto_s, step_s, MODE_MASK, 1'(DWELL_FRAMES)};
`endif

   assign inymode     = inymode_reg;
   assign mixnoise    = mixnoise_reg;
   assign usewobble   = usewobble_reg;
   assign osel        = osel_reg;
   assign cfg_update  = cfg_update_reg;
   assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_mode_scheduler.sv
// Self-checking bench for vga_mode_scheduler: frame-level reference model, randomized pins.
// AUTO scenarios are exercised when MODESCHED_AUTO_EN is defined.
module tb_vga_mode_scheduler;

   localparam int         DW   = 3;
   localparam logic [7:0] MASK = 8'b1010_0101;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b1;
   logic [2:0] ui_mode = '0;
   logic       ui_mixnoise = 1'b0;
   logic       ui_usewobble = 1'b0;
   logic [1:0] ui_osel = '0;
   logic       ui_auto = 1'b0;
   logic       ui_step = 1'b0;

   logic [2:0] inymode;
   logic       mixnoise;
   logic       usewobble;
   logic [1:0] osel;
   logic       cfg_update;
   logic [7:0] frame_count;

   int errors = 0;
   int checks = 0;
   int cfg_total = 0;
   int frame_no = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cfg_update) cfg_total++;
   end

   vga_mode_scheduler #(
      .DWELL_FRAMES  (DW),
      .MODE_MASK     (MASK),
      .VSYNC_ACT_LOW (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vsync        (vsync),
      .ui_mode      (ui_mode),
      .ui_mixnoise  (ui_mixnoise),
      .ui_usewobble (ui_usewobble),
      .ui_osel      (ui_osel),
      .ui_auto      (ui_auto),
      .ui_step      (ui_step),
      .inymode      (inymode),
      .mixnoise     (mixnoise),
      .usewobble    (usewobble),
      .osel         (osel),
      .cfg_update   (cfg_update),
      .frame_count  (frame_count)
   );

   typedef struct {
      int mode;
      int mix;
      int wob;
      int osel;
      int fc;
      int dwell;
      bit automode;
      bit step_prev;
   } model_t;

   model_t mdl;

`ifdef MODESCHED_AUTO_EN
   logic [2:0] z_inymode;
   logic       z_mixnoise;
   logic       z_usewobble;
   logic [1:0] z_osel;
   logic       z_cfg_update;
   logic [7:0] z_frame_count;
   model_t     mdl_z;

   vga_mode_scheduler #(
      .DWELL_FRAMES  (DW),
      .MODE_MASK     (8'h00),
      .VSYNC_ACT_LOW (1)
   ) dut_z (
      .clk          (clk),
      .rst          (rst),
      .vsync        (vsync),
      .ui_mode      (ui_mode),
      .ui_mixnoise  (ui_mixnoise),
      .ui_usewobble (ui_usewobble),
      .ui_osel      (ui_osel),
      .ui_auto      (ui_auto),
      .ui_step      (ui_step),
      .inymode      (z_inymode),
      .mixnoise     (z_mixnoise),
      .usewobble    (z_usewobble),
      .osel         (z_osel),
      .cfg_update   (z_cfg_update),
      .frame_count  (z_frame_count)
   );

   // Enabled modes listed in ascending order; pick the first one above cur, else wrap.
   function automatic int model_next(input int cur, input logic [7:0] mask);
      int en[$];
      for (int i = 0; i < 8; i++) if (mask[i]) en.push_back(i);
      if (en.size() == 0) return cur;
      foreach (en[k]) if (en[k] > cur) return en[k];
      return en[0];
   endfunction
`endif

   function automatic model_t model_fb(input model_t m, input logic [7:0] mask,
                                       input int mode_in, input int mix_in, input int wob_in,
                                       input int osel_in, input bit auto_in, input bit step_in);
      model_t r;
      r      = m;
      r.mix  = mix_in;
      r.wob  = wob_in;
      r.osel = osel_in;
      r.fc   = (m.fc + 1) % 256;
`ifdef MODESCHED_AUTO_EN
      begin
         bit evt;
         evt         = step_in && !m.step_prev;
         r.step_prev = step_in;
         if (!m.automode) begin
            if (auto_in) begin
               r.automode = 1'b1;
               r.dwell    = 0;
            end else begin
               r.mode = mode_in;
            end
         end else if (!auto_in) begin
            r.automode = 1'b0;
            r.mode     = mode_in;
         end else if (evt || m.dwell == DW - 1) begin
            r.mode  = model_next(m.mode, mask);
            r.dwell = 0;
         end else begin
            r.dwell = m.dwell + 1;
         end
      end
`else
      // auto/step requests have no effect in the manual-only build
      r.automode  = 1'b0;
      r.step_prev = step_in;
      r.dwell     = (auto_in && mask != 8'h00) ? 0 : 0;
      r.mode      = mode_in;
`endif
      return r;
   endfunction

   function automatic logic [14:0] pack_model(input model_t m);
      return {3'(m.mode), 1'(m.mix), 1'(m.wob), 2'(m.osel), 8'(m.fc)};
   endfunction

   function automatic logic [14:0] pack_dut();
      return {inymode, mixnoise, usewobble, osel, frame_count};
   endfunction

   // One vsync frame: pins settle, vsync goes active (low) then inactive; ends #1 after an edge.
   task automatic frame();
      repeat (6) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (4) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic fb_step();
      frame();
      mdl = model_fb(mdl, MASK, int'(ui_mode), int'(ui_mixnoise), int'(ui_usewobble),
                     int'(ui_osel), ui_auto, ui_step);
`ifdef MODESCHED_AUTO_EN
      mdl_z = model_fb(mdl_z, 8'h00, int'(ui_mode), int'(ui_mixnoise), int'(ui_usewobble),
                       int'(ui_osel), ui_auto, ui_step);
`endif
      frame_no++;
      $display("frame %0d: inymode=%0d mix=%0d wob=%0d osel=%0d fc=%0d",
               frame_no, inymode, mixnoise, usewobble, osel, frame_count);
   endtask

   task automatic model_reset();
      mdl = '{default: 0};
`ifdef MODESCHED_AUTO_EN
      mdl_z = '{default: 0};
`endif
   endtask

   task automatic test_reset();
      int c0;
      rst = 1'b1;
      ui_mode = 3'd7; ui_mixnoise = 1'b1; ui_usewobble = 1'b1; ui_osel = 2'd3;
      c0 = cfg_total;
      for (int k = 0; k < 3; k++) begin
         frame();
         checks++;
         if (pack_dut() !== 15'd0 || cfg_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold frame %0d: got %h cfg=%b, expected 0000 cfg=0", k, pack_dut(), cfg_update);
         end
      end
      checks++;
      if (cfg_total != c0) begin
         errors++;
         $display("FAIL reset_cfg_pulses: got %0d, expected 0", cfg_total - c0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      ui_mode = '0; ui_mixnoise = 1'b0; ui_usewobble = 1'b0; ui_osel = '0;
   endtask

   task automatic test_manual_latency();
      int c0;
      c0 = cfg_total;
      ui_mode = 3'd5; ui_osel = 2'd2; ui_auto = 1'b0; ui_step = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (pack_dut() !== 15'd0) begin
         errors++;
         $display("FAIL latency_pre_fb: got %h, expected 0000", pack_dut());
      end
      vsync = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (inymode !== 3'd0 || cfg_update !== 1'b0) begin
         errors++;
         $display("FAIL latency_fb_cycle: got inymode=%0d cfg=%b, expected 0/0", inymode, cfg_update);
      end
      @(posedge clk); #1;
      checks++;
      if (inymode !== 3'd5 || osel !== 2'd2 || cfg_update !== 1'b1 || frame_count !== 8'd1) begin
         errors++;
         $display("FAIL latency_reload: got inymode=%0d osel=%0d cfg=%b fc=%0d, expected 5 2 1 1",
                  inymode, osel, cfg_update, frame_count);
      end
      @(posedge clk); #1;
      checks++;
      if (cfg_update !== 1'b0) begin
         errors++;
         $display("FAIL latency_cfg_width: got cfg=%b, expected 0", cfg_update);
      end
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cfg_total - c0 != 1) begin
         errors++;
         $display("FAIL latency_cfg_count: got %0d pulses, expected 1", cfg_total - c0);
      end
      mdl = model_fb(mdl, MASK, 5, 0, 0, 2, 1'b0, 1'b0);
`ifdef MODESCHED_AUTO_EN
      mdl_z = model_fb(mdl_z, 8'h00, 5, 0, 0, 2, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_random_manual();
      int c0;
      for (int k = 0; k < 24; k++) begin
         ui_mode      = 3'($urandom_range(0, 7));
         ui_mixnoise  = 1'($urandom_range(0, 1));
         ui_usewobble = 1'($urandom_range(0, 1));
         ui_osel      = 2'($urandom_range(0, 3));
         ui_step      = 1'($urandom_range(0, 1));
         ui_auto      = 1'b0;
         c0 = cfg_total;
         fb_step();
         checks++;
         if (pack_dut() !== pack_model(mdl)) begin
            errors++;
            $display("FAIL rand_manual frame %0d: got %h, expected %h", k, pack_dut(), pack_model(mdl));
         end
         checks++;
         if (cfg_total - c0 != 1) begin
            errors++;
            $display("FAIL rand_manual_cfg frame %0d: got %0d pulses, expected 1", k, cfg_total - c0);
         end
      end
   endtask

`ifdef MODESCHED_AUTO_EN
   task automatic test_auto_dwell();
      int exp_seq[4] = '{2, 5, 7, 0};
      ui_mode = 3'd0; ui_auto = 1'b0; ui_step = 1'b0;
      fb_step();
      ui_auto = 1'b1;
      for (int j = 1; j <= 13; j++) begin
         fb_step();
         checks++;
         if (pack_dut() !== pack_model(mdl)) begin
            errors++;
            $display("FAIL auto_dwell_model frame %0d: got %h, expected %h", j, pack_dut(), pack_model(mdl));
         end
         if (j >= 4 && (j - 1) % 3 == 0) begin
            checks++;
            if (inymode !== 3'(exp_seq[(j - 4) / 3])) begin
               errors++;
               $display("FAIL auto_dwell_seq frame %0d: got %0d, expected %0d", j, inymode, exp_seq[(j - 4) / 3]);
            end
         end
      end
      checks++;
      if (z_inymode !== 3'd0) begin
         errors++;
         $display("FAIL mask_zero_frozen: got %0d, expected 0", z_inymode);
      end
   endtask

   task automatic test_step_dwell();
      int prev;
      int exp_mode;
      ui_step = 1'b0;
      for (int k = 0; k < 4 && mdl.dwell != DW - 1; k++) fb_step();
      prev = mdl.mode;
      ui_step = 1'b1;
      fb_step();
      exp_mode = model_next(prev, MASK);
      checks++;
      if (inymode !== 3'(exp_mode)) begin
         errors++;
         $display("FAIL step_and_dwell: got %0d, expected %0d", inymode, exp_mode);
      end
      ui_step = 1'b0;
      fb_step();
      prev = mdl.mode;
      ui_step = 1'b1;
      for (int k = 0; k < 10; k++) begin
         fb_step();
         checks++;
         if (pack_dut() !== pack_model(mdl)) begin
            errors++;
            $display("FAIL step_hold_model frame %0d: got %h, expected %h", k, pack_dut(), pack_model(mdl));
         end
      end
      exp_mode = prev;
      for (int k = 0; k < 4; k++) exp_mode = model_next(exp_mode, MASK);
      checks++;
      if (inymode !== 3'(exp_mode)) begin
         errors++;
         $display("FAIL step_hold_once: got %0d, expected %0d", inymode, exp_mode);
      end
      ui_step = 1'b0;
   endtask

   task automatic test_auto_exit();
      ui_mode = 3'd6; ui_auto = 1'b0;
      fb_step();
      checks++;
      if (inymode !== 3'd6) begin
         errors++;
         $display("FAIL auto_exit: got %0d, expected 6", inymode);
      end
      ui_mode = 3'd3;
      ui_auto = 1'b1;
      repeat (4) @(posedge clk);
      #1 ui_auto = 1'b0;
      fb_step();
      checks++;
      if (inymode !== 3'd3 || pack_dut() !== pack_model(mdl)) begin
         errors++;
         $display("FAIL auto_glitch_ignored: got %0d, expected 3", inymode);
      end
   endtask

   task automatic test_random_auto();
      for (int k = 0; k < 40; k++) begin
         ui_mode      = 3'($urandom_range(0, 7));
         ui_mixnoise  = 1'($urandom_range(0, 1));
         ui_usewobble = 1'($urandom_range(0, 1));
         ui_osel      = 2'($urandom_range(0, 3));
         ui_auto      = ($urandom_range(0, 7) != 0);
         ui_step      = 1'($urandom_range(0, 1));
         fb_step();
         checks++;
         if (pack_dut() !== pack_model(mdl)) begin
            errors++;
            $display("FAIL rand_auto frame %0d: got %h, expected %h", k, pack_dut(), pack_model(mdl));
         end
         checks++;
         if (z_inymode !== 3'(mdl_z.mode)) begin
            errors++;
            $display("FAIL rand_auto_mask0 frame %0d: got %0d, expected %0d", k, z_inymode, mdl_z.mode);
         end
      end
      ui_auto = 1'b0;
      ui_step = 1'b0;
   endtask
`else
   task automatic test_auto_ignored();
      for (int k = 0; k < 12; k++) begin
         ui_mode = 3'($urandom_range(0, 7));
         ui_auto = 1'b1;
         ui_step = 1'(k % 2);
         fb_step();
         checks++;
         if (inymode !== ui_mode || pack_dut() !== pack_model(mdl)) begin
            errors++;
            $display("FAIL auto_ignored frame %0d: got %0d, expected %0d", k, inymode, ui_mode);
         end
      end
      ui_auto = 1'b0;
      ui_step = 1'b0;
   endtask
`endif

   task automatic test_midframe_reset();
      ui_mode = 3'd3; ui_osel = 2'd1; ui_mixnoise = 1'b1; ui_usewobble = 1'b0; ui_auto = 1'b0;
      fb_step();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (pack_dut() !== 15'd0 || cfg_update !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset: got %h, expected 0000", pack_dut());
      end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      ui_mode = 3'd4; ui_osel = 2'd3; ui_mixnoise = 1'b1; ui_usewobble = 1'b1;
      fb_step();
      checks++;
      if (pack_dut() !== pack_model(mdl) || frame_count !== 8'd1) begin
         errors++;
         $display("FAIL reset_fresh_cfg: got %h, expected %h", pack_dut(), pack_model(mdl));
      end
   endtask

   task automatic test_frame_wrap();
      ui_auto = 1'b0;
      for (int k = 0; k < 300 && mdl.fc != 255; k++) fb_step();
      checks++;
      if (frame_count !== 8'd255) begin
         errors++;
         $display("FAIL wrap_pre: got %0d, expected 255", frame_count);
      end
      fb_step();
      checks++;
      if (frame_count !== 8'd0 || pack_dut() !== pack_model(mdl)) begin
         errors++;
         $display("FAIL wrap_post: got %0d, expected 0", frame_count);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_manual_latency();
      test_random_manual();
`ifdef MODESCHED_AUTO_EN
      test_auto_dwell();
      test_step_dwell();
      test_auto_exit();
      test_random_auto();
`else
      test_auto_ignored();
`endif
      test_midframe_reset();
      test_frame_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
